// File: rtl/alu_share_arb.sv
// ----------------------------------------------------------------------------
// alu_share_arb.sv
//
// Purpose:
//    One combinational ALU shared by two requesters (for example the execute
//    stage and an address-generation/CSR path). A round-robin arbiter picks at
//    most one request per cycle. Each requester owns a one-entry registered
//    response buffer, so a result is visible the cycle after its request is
//    accepted. Saturating per-requester grant counters are kept for perf.
//
// Contents (in order):
//    lib_pkg        - operation enumeration shared with the requesters
//    alu            - purely combinational ALU (ADD..AND)
//    alu_share_arb  - arbiter, response buffers and grant counters (top)
//
// Top-level ports:
//    clk         in   1          clock, all state updates on the rising edge
//    rst         in   1          synchronous reset, active-high
//    req0_valid  in   1          requester 0 presents an operation
//    req0_ready  out  1          requester 0 operation accepted this cycle
//    req0_op     in   op_type_t  requester 0 operation
//    req0_in0    in   WIDTH      requester 0 operand 0
//    req0_in1    in   WIDTH      requester 0 operand 1
//    rsp0_valid  out  1          requester 0 result is held in its buffer
//    rsp0_ready  in   1          requester 0 consumes the held result
//    rsp0_data   out  WIDTH      requester 0 result
//    req1_* / rsp1_*             identical set for requester 1
//    gnt0_cnt    out  CNT_W      accepted operations of requester 0, saturating
//    gnt1_cnt    out  CNT_W      accepted operations of requester 1, saturating
// ----------------------------------------------------------------------------

package lib_pkg;

    // Operation codes understood by the shared ALU.
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        SLL  = 4'd2,
        SLT  = 4'd3,
        SLTU = 4'd4,
        XOR  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        OR   = 4'd8,
        AND  = 4'd9
    } op_type_t;

endpackage : lib_pkg

// ----------------------------------------------------------------------------
// alu
//
// Purpose:
//    Combinational ALU. Add/sub wrap modulo 2^WIDTH, shift amount comes from
//    the low five bits of operand 1, set-less-than results are 0/1 and
//    zero-extended to WIDTH.
//
// Ports:
//    i_op    in   op_type_t  operation
//    i_in0   in   WIDTH      operand 0
//    i_in1   in   WIDTH      operand 1 (also the shift amount source)
//    o_out   out  WIDTH      result
// ----------------------------------------------------------------------------
module alu #(
    parameter int WIDTH = 32
) (
    input  lib_pkg::op_type_t  i_op,
    input  logic [WIDTH-1:0]   i_in0,
    input  logic [WIDTH-1:0]   i_in1,
    output logic [WIDTH-1:0]   o_out
);

    import lib_pkg::*;

    logic [4:0] w_shamt;
    logic       w_slt;
    logic       w_sltu;

    // Only the low five bits of operand 1 select the shift distance, so a
    // shift by 0x21 behaves exactly like a shift by 1.
    assign w_shamt = i_in1[4:0];

    // Signed and unsigned comparisons are formed once and zero-extended
    // below so both set-less-than flavours share the same result shape.
    assign w_slt  = $signed(i_in0) < $signed(i_in1);
    assign w_sltu = i_in0 < i_in1;

    // Result select. An unknown opcode yields zero rather than holding a
    // stale value, which keeps this block free of inferred storage.
    always_comb begin
        o_out = '0;
        case (i_op)
            ADD:     o_out = i_in0 + i_in1;
            SUB:     o_out = i_in0 - i_in1;
            SLL:     o_out = i_in0 << w_shamt;
            SLT:     o_out = {{(WIDTH-1){1'b0}}, w_slt};
            SLTU:    o_out = {{(WIDTH-1){1'b0}}, w_sltu};
            XOR:     o_out = i_in0 ^ i_in1;
            SRL:     o_out = i_in0 >> w_shamt;
            SRA:     o_out = $unsigned($signed(i_in0) >>> w_shamt);
            OR:      o_out = i_in0 | i_in1;
            AND:     o_out = i_in0 & i_in1;
            default: o_out = '0;
        endcase
    end

endmodule : alu

// ----------------------------------------------------------------------------
// alu_share_arb (top)
//
// Purpose:
//    Arbitrates two valid/ready requesters onto one ALU and returns each
//    result through that requester's own one-entry response buffer.
//    See the file header for the port summary.
// ----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  lib_pkg::op_type_t   req0_op,
    input  logic [WIDTH-1:0]    req0_in0,
    input  logic [WIDTH-1:0]    req0_in1,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [WIDTH-1:0]    rsp0_data,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  lib_pkg::op_type_t   req1_op,
    input  logic [WIDTH-1:0]    req1_in0,
    input  logic [WIDTH-1:0]    req1_in1,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WIDTH-1:0]    rsp1_data,

    output logic [CNT_W-1:0]    gnt0_cnt,
    output logic [CNT_W-1:0]    gnt1_cnt
);

    import lib_pkg::*;

    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [WIDTH-1:0]   r_rsp0_data;
    logic [WIDTH-1:0]   r_rsp1_data;
    logic [CNT_W-1:0]   r_gnt0_cnt;
    logic [CNT_W-1:0]   r_gnt1_cnt;
    logic               r_last_gnt;

    logic               w_elig0;
    logic               w_elig1;
    logic               w_gnt0;
    logic               w_gnt1;
    op_type_t           w_alu_op;
    logic [WIDTH-1:0]   w_alu_in0;
    logic [WIDTH-1:0]   w_alu_in1;
    logic [WIDTH-1:0]   w_alu_out;

    // A requester may compete only when its response slot is empty or is
    // being drained in this same cycle; a stalled response blocks its owner
    // but never the other requester.
    assign w_elig0 = req0_valid & (~r_rsp0_valid | rsp0_ready);
    assign w_elig1 = req1_valid & (~r_rsp1_valid | rsp1_ready);

    // Round-robin grant: a lone eligible requester always wins; on a tie the
    // requester that was not granted last wins. Requester 1 is granted only
    // when requester 0 is not, so at most one accept happens per cycle.
    assign w_gnt0 = w_elig0 & (~w_elig1 | r_last_gnt);
    assign w_gnt1 = w_elig1 & ~w_gnt0;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // The ALU inputs follow the granted requester. With no grant the
    // requester 0 operands pass through harmlessly because nothing captures
    // the result; operands are therefore sampled only in the accept cycle.
    always_comb begin
        w_alu_op  = req0_op;
        w_alu_in0 = req0_in0;
        w_alu_in1 = req0_in1;
        if (w_gnt1) begin
            w_alu_op  = req1_op;
            w_alu_in0 = req1_in0;
            w_alu_in1 = req1_in1;
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op  (w_alu_op),
        .i_in0 (w_alu_in0),
        .i_in1 (w_alu_in1),
        .o_out (w_alu_out)
    );

    // Requester 0 response buffer. A new accept always wins over a drain, so
    // draining and refilling the slot in one cycle keeps valid high with the
    // new data; a plain drain clears valid but leaves the data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
        end else if (w_gnt0) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_data  <= w_alu_out;
        end else if (r_rsp0_valid && rsp0_ready) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    // Requester 1 response buffer, same behaviour as requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
        end else if (w_gnt1) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_data  <= w_alu_out;
        end else if (r_rsp1_valid && rsp1_ready) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    // Round-robin history. It resets to requester 1 so that requester 0 wins
    // the first tie, and it moves only on an accept so idle cycles do not
    // disturb the fairness order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (w_gnt0) begin
            r_last_gnt <= 1'b0;
        end else if (w_gnt1) begin
            r_last_gnt <= 1'b1;
        end
    end

    // Grant counters for performance monitoring. They stick at all-ones
    // instead of wrapping so a long run never reports a misleadingly small
    // count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else begin
            if (w_gnt0 && (r_gnt0_cnt != {CNT_W{1'b1}})) begin
                r_gnt0_cnt <= r_gnt0_cnt + CNT_W'(1);
            end
            if (w_gnt1 && (r_gnt1_cnt != {CNT_W{1'b1}})) begin
                r_gnt1_cnt <= r_gnt1_cnt + CNT_W'(1);
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign gnt0_cnt   = r_gnt0_cnt;
    assign gnt1_cnt   = r_gnt1_cnt;

endmodule : alu_share_arb
